// File: rtl/spi_tx_framer_pkg.sv
// Shared types and constants for the SPI transmit framer.
package spi_tx_pkg;

    localparam int BYTE_W = 8;

    localparam logic [BYTE_W-1:0] HDR0_DEF = 8'hA5;
    localparam logic [BYTE_W-1:0] HDR1_DEF = 8'h5A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM
    } state_t;

endpackage

// File: rtl/spi_tx_framer_if.sv
// Byte-input and serialiser-facing signals of the SPI transmit framer.
interface spi_tx_framer_if;
    import spi_tx_pkg::*;

    logic [BYTE_W-1:0] pix_data;
    logic              pix_valid;
    logic              cs_n;
    logic [2:0]        cnt_bit;
    logic [BYTE_W-1:0] data_out;
    logic              valid;
    logic              fifo_full;
    logic              overflow;
    logic              frame_busy;

    modport master (
        output pix_data, pix_valid, cs_n, cnt_bit,
        input  data_out, valid, fifo_full, overflow, frame_busy
    );

    modport slave (
        input  pix_data, pix_valid, cs_n, cnt_bit,
        output data_out, valid, fifo_full, overflow, frame_busy
    );

endinterface

// File: rtl/spi_tx_framer_fifo.sv
// Single-clock payload FIFO with a combinational head read and registered full flag.
module spi_tx_fifo
    import spi_tx_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout,
    output logic              full,
    output logic [AW:0]       count
);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_full;
    logic [AW:0]       w_count_next;
    logic              w_push;
    logic              w_pop;

    // Guarded locally so a careless caller cannot corrupt the pointers.
    assign w_push = push && !r_full;
    assign w_pop  = pop && (r_count != '0);

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == (AW+1)'(DEPTH));
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign count = r_count;

endmodule

// File: rtl/spi_tx_framer.sv
// Frames buffered payload bytes as HDR0 HDR1 LEN payload [CSUM] for the SPI serialiser.
// Define SPI_TX_CSUM_EN to append a modulo-256 payload checksum byte.
module spi_tx_framer
    import spi_tx_pkg::*;
#(
    parameter int                PAYLOAD_LEN = 8,
    parameter int                FIFO_DEPTH  = 16,
    parameter logic [BYTE_W-1:0] HDR0        = HDR0_DEF,
    parameter logic [BYTE_W-1:0] HDR1        = HDR1_DEF
) (
    input  logic           sck,
    input  logic           sys_rst_n,
    spi_tx_framer_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]     PLEN_CNT = CW'(PAYLOAD_LEN);
    localparam logic [BYTE_W-1:0] PLEN_B   = BYTE_W'(PAYLOAD_LEN);
    localparam logic [7:0]        PLEN_LAST = 8'(PAYLOAD_LEN - 1);

    state_t            r_state;
    logic [7:0]        r_pay_cnt;
    logic              r_overflow;
    logic [BYTE_W-1:0] w_head;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic              w_valid;
    logic              w_byte_done;
    logic [BYTE_W-1:0] w_data_out;
`ifdef SPI_TX_CSUM_EN
    logic [BYTE_W-1:0] r_csum;
`endif

    assign w_valid     = (r_state != ST_IDLE);
    assign w_byte_done = w_valid && !bus.cs_n && (bus.cnt_bit == 3'd7);
    assign w_push      = bus.pix_valid && !w_full;
    assign w_pop       = (r_state == ST_PAYLOAD) && w_byte_done;

    spi_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (sck),
        .rst_n (sys_rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.pix_data),
        .dout  (w_head),
        .full  (w_full),
        .count (w_count)
    );

    // Starting only with a full payload buffered means PAYLOAD can never underrun.
    always_ff @(posedge sck or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= ST_IDLE;
            r_pay_cnt  <= '0;
            r_overflow <= 1'b0;
`ifdef SPI_TX_CSUM_EN
            r_csum     <= '0;
`endif
        end else begin
            if (bus.pix_valid && w_full) r_overflow <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_count >= PLEN_CNT) begin
                        r_state <= ST_HDR0;
`ifdef SPI_TX_CSUM_EN
                        r_csum  <= '0;
`endif
                    end
                end
                ST_HDR0: if (w_byte_done) r_state <= ST_HDR1;
                ST_HDR1: if (w_byte_done) r_state <= ST_LEN;
                ST_LEN: begin
                    if (w_byte_done) begin
                        r_state   <= ST_PAYLOAD;
                        r_pay_cnt <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_byte_done) begin
                        r_pay_cnt <= r_pay_cnt + 1'b1;
`ifdef SPI_TX_CSUM_EN
                        r_csum    <= r_csum + w_head;
                        if (r_pay_cnt == PLEN_LAST) r_state <= ST_CSUM;
`else
                        if (r_pay_cnt == PLEN_LAST) r_state <= ST_IDLE;
`endif
                    end
                end
`ifdef SPI_TX_CSUM_EN
                ST_CSUM: if (w_byte_done) r_state <= ST_IDLE;
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_data_out = '0;
        case (r_state)
            ST_HDR0:    w_data_out = HDR0;
            ST_HDR1:    w_data_out = HDR1;
            ST_LEN:     w_data_out = PLEN_B;
            ST_PAYLOAD: w_data_out = w_head;
`ifdef SPI_TX_CSUM_EN
            ST_CSUM:    w_data_out = r_csum;
`endif
            default:    w_data_out = '0;
        endcase
    end

    assign bus.data_out   = w_data_out;
    assign bus.valid      = w_valid;
    assign bus.frame_busy = w_valid;
    assign bus.fifo_full  = w_full;
    assign bus.overflow   = r_overflow;

endmodule

// File: tb/tb_spi_tx_framer.sv
// Directed-plus-random bench for spi_tx_framer against a queue-based frame model.
module tb_spi_tx_framer;

    localparam int PLEN  = 8;
    localparam int DEPTH = 16;
`ifdef SPI_TX_CSUM_EN
    localparam int FL = PLEN + 4;
`else
    localparam int FL = PLEN + 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_tx_framer_if bus ();

    spi_tx_framer #(.PAYLOAD_LEN(PLEN), .FIFO_DEPTH(DEPTH)) dut (
        .sck       (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    logic [7:0] pushed[$];
    logic [2:0] ser_cnt   = 3'd0;
    int         idx       = 0;
    bit         in_frame  = 0;
    bit         start_due = 0;
    bit         m_ovf     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic build_frame();
        logic [7:0] sum;
        sum = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'(PLEN));
        for (int i = 0; i < PLEN && i < mq.size(); i++) begin
            exp_q.push_back(mq[i]);
            sum = sum + mq[i];
        end
`ifdef SPI_TX_CSUM_EN
        exp_q.push_back(sum);
`endif
    endtask

    // One clock: drive inputs, advance the model across the edge, then check outputs.
    task automatic cycle(input bit pv, input logic [7:0] pd, input bit csn);
        bit v_pre, bd, frame_end, new_byte;
        bus.pix_valid = pv;
        bus.pix_data  = pd;
        bus.cs_n      = csn;
        bus.cnt_bit   = ser_cnt;
        v_pre     = bus.valid;
        bd        = v_pre && !csn && (ser_cnt == 3'd7);
        frame_end = 0;
        new_byte  = 0;
        if (bd && in_frame) begin
            if (idx >= 3 && idx < 3 + PLEN) void'(mq.pop_front());
            idx++;
            if (idx == FL) frame_end = 1;
            else new_byte = 1;
        end
        if (pv && mq.size() < DEPTH) begin
            mq.push_back(pd);
            pushed.push_back(pd);
        end else if (pv) begin
            m_ovf = 1;
        end
        @(posedge clk);
        #1;
        if (!bus.valid || bd) ser_cnt = 3'd0;
        else if (v_pre && !csn) ser_cnt = ser_cnt + 3'd1;
        chk("overflow", bus.overflow, m_ovf);
        chk("fifo_full", bus.fifo_full, (mq.size() == DEPTH));
        if (frame_end) begin
            in_frame = 0;
            chk("gap_valid", bus.valid, 0);
            start_due = (mq.size() >= PLEN);
        end else if (!in_frame) begin
            chk("idle_start", bus.valid, start_due);
            if (bus.valid) begin
                build_frame();
                in_frame = 1;
                idx      = 0;
                new_byte = 1;
            end else begin
                start_due = (mq.size() >= PLEN);
            end
        end
        if (in_frame) begin
            chk("data_out", bus.data_out, exp_q[idx]);
            chk("frame_busy", bus.frame_busy, 1);
            if (new_byte) log_q.push_back(bus.data_out);
        end else begin
            chk("idle_data", bus.data_out, 8'h00);
            chk("idle_busy", bus.frame_busy, 0);
        end
    endtask

    task automatic do_reset();
        bus.pix_valid = 1'b0;
        bus.pix_data  = 8'h00;
        bus.cs_n      = 1'b1;
        bus.cnt_bit   = 3'd0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_data", bus.data_out, 8'h00);
        chk("rst_valid", bus.valid, 0);
        chk("rst_busy", bus.frame_busy, 0);
        chk("rst_full", bus.fifo_full, 0);
        chk("rst_ovf", bus.overflow, 0);
        mq.delete();
        exp_q.delete();
        ser_cnt = 3'd0;
        idx = 0;
        in_frame = 0;
        start_due = 0;
        m_ovf = 0;
        rst_n = 1'b1;
    endtask

    task automatic drain(input int bound);
        for (int n = 0; n < bound; n++) begin
            if (!in_frame && !start_due && mq.size() < PLEN) break;
            cycle(1'b0, 8'h00, 1'b0);
        end
        chk("drain_valid", bus.valid, 0);
    endtask

    initial begin
        logic [7:0] golden[$];
        logic [7:0] held;
        int n;

        // Reset state
        do_reset();

        // Insufficient data, then a single frame of 01..08
        log_q.delete();
        for (int i = 1; i <= 7; i++) cycle(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0);
        chk("short_valid", bus.valid, 0);
        cycle(1'b1, 8'h08, 1'b0);
        chk("eighth_pending", bus.valid, 0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("start_valid", bus.valid, 1);
        chk("start_hdr0", bus.data_out, 8'hA5);
        drain(400);
        golden = '{8'hA5, 8'h5A, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
`ifdef SPI_TX_CSUM_EN
        golden.push_back(8'h24);
`endif
        chk("stream_len", log_q.size(), golden.size());
        for (int i = 0; i < golden.size() && i < log_q.size(); i++)
            chk($sformatf("stream[%0d]", i), log_q[i], golden[i]);

        // Overflow: 17 random bytes with cs_n high
        log_q.delete();
        pushed.delete();
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 8'($urandom_range(0, 255)), 1'b1);
            if (i == 15) chk("full_at16", bus.fifo_full, 1);
            if (i == 15) chk("no_ovf_at16", bus.overflow, 0);
        end
        chk("ovf_at17", bus.overflow, 1);
        drain(800);
        chk("ovf_sticky", bus.overflow, 1);
        chk("ovf_log_len", log_q.size(), 2 * FL);
        for (int i = 0; i < PLEN && 3 + i < log_q.size(); i++)
            chk($sformatf("ovf_pay[%0d]", i), log_q[3 + i], pushed[i]);

        // Chip-select pause in the 4th payload byte
        do_reset();
        pushed.delete();
        for (int i = 0; i < PLEN; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        n = 0;
        while (!(in_frame && idx == 6 && ser_cnt == 3'd3) && n < 200) begin
            cycle(1'b0, 8'h00, 1'b0);
            n++;
        end
        chk("pause_reached", idx, 6);
        held = pushed[3];
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 8'h00, 1'b1);
            chk("cs_hold", bus.data_out, held);
        end
        drain(400);

        // Reset mid-frame discards buffered bytes
        for (int i = 0; i < PLEN + 3; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        chk("pre_rst_busy", bus.frame_busy, 1);
        do_reset();
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0);
        chk("post_rst_idle", bus.valid, 0);
        cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        chk("post_rst_start", bus.data_out, 8'hA5);
        drain(400);

        // Back-to-back frames from 16 consecutive pushes
        log_q.delete();
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
        drain(800);
        chk("b2b_log_len", log_q.size(), 2 * FL);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_tx_framer.md
Name: spi_tx_framer

Overview:
Upstream neighbour of the SPI byte-serialiser stage, clocked on the same SPI serial clock.
- Buffers incoming sensor bytes in a small FIFO.
- Wraps each PAYLOAD_LEN-byte block in a frame: two header bytes, a length byte, the payload, and an optional checksum.
- Presents one byte at a time on data_out/valid.
- Advances to the next byte when the serialiser's bit counter reports the last bit of the current byte under an active chip select.

Parameters:
- PAYLOAD_LEN, 8, payload bytes per frame. Range 1..255; must be ≤ FIFO_DEPTH.
- FIFO_DEPTH, 16, payload FIFO depth. Power of two.
- HDR0, 8'hA5, first frame header byte.
- HDR1, 8'h5A, second frame header byte.

Ports:
- sck  input  1  clock. All logic on posedge.
- sys_rst_n  input  1  asynchronous, active-low reset.
- pix_data  input  8  byte to enqueue.
- pix_valid  input  1  enqueue strobe, one byte per cycle.
- cs_n  input  1  SPI chip select, active low.
- cnt_bit  input  3  bit index from the serialiser stage.
- data_out  output  8  current frame byte for the serialiser.
- valid  output  1  data_out holds a frame byte.
- fifo_full  output  1  FIFO holds FIFO_DEPTH bytes.
- overflow  output  1  sticky flag: a byte was dropped.
- frame_busy  output  1  a frame is in progress (state ≠ IDLE).

Behaviour:
- Reset values: state IDLE, FIFO pointers and count 0, csum 0, data_out 8'h00, valid 0, fifo_full 0, overflow 0, frame_busy 0.
- Enqueue on pix_valid && !fifo_full, taking effect in the same cycle.
- pix_valid while fifo_full: byte is dropped and overflow is set. overflow stays set until reset.
- byte_done = valid && !cs_n && (cnt_bit == 3'd7). This is the only condition that advances the state.
- States and transitions:
  - IDLE → HDR0 when FIFO count ≥ PAYLOAD_LEN. This guarantees no underrun mid-frame.
  - HDR0 → HDR1 → LEN → PAYLOAD, each on byte_done.
  - PAYLOAD: pop one FIFO byte on each byte_done. Leave after PAYLOAD_LEN pops, going to CSUM (or IDLE when the checksum is compiled out).
  - CSUM → IDLE on byte_done.
- data_out is a combinational mux of registered state, so it is stable for a whole byte:
  - IDLE: 8'h00.
  - HDR0: HDR0.
  - HDR1: HDR1.
  - LEN: PAYLOAD_LEN[7:0].
  - PAYLOAD: FIFO head.
  - CSUM: csum.
- valid = 1 in every state except IDLE.
- The new byte appears in the cycle after byte_done, i.e. when the serialiser's cnt_bit wraps to 0. There are no gap cycles between bytes.
- Payload byte counter: 8 bits. Cleared on entry to PAYLOAD; incremented on each payload byte_done.
- Simultaneous enqueue and pop: both take effect and the count is unchanged.
- fifo_full is registered and reflects the count after the current cycle's push/pop.
- cs_n high mid-frame: state, byte counter and csum hold. The frame resumes on the next cs_n low; there is no abort.
- Reset mid-frame: everything returns to reset values and buffered bytes are discarded.
- IDLE → HDR0 may occur in the same cycle as the final byte_done of the previous frame (CSUM → IDLE) only via IDLE. The minimum gap is one cycle with valid = 0.

Optional Feature:
- Macro: SPI_TX_CSUM_EN.
- Defined:
  - CSUM state is present.
  - csum is cleared on entry to HDR0 and accumulates each popped payload byte, modulo 256.
  - Frame length is PAYLOAD_LEN + 4 bytes.
- Undefined:
  - No CSUM state and no csum register; PAYLOAD → IDLE directly.
  - Frame length is PAYLOAD_LEN + 3 bytes.

Decomposition:
- Package spi_tx_pkg holds:
  - state encoding (IDLE, HDR0, HDR1, LEN, PAYLOAD, CSUM);
  - default header constants;
  - byte width constant (8).
- One sub-module, spi_tx_fifo: synchronous single-clock FIFO.
  - Ports: push, pop, din, dout (head, combinational read), full, count.
  - Reset: asynchronous, active-low, on sys_rst_n.

Test Plan:
- Reset: sys_rst_n low mid-frame → next cycle data_out = 8'h00, valid = 0, frame_busy = 0, fifo_full = 0, overflow = 0; a following frame starts only after 8 new bytes.
- Single frame (CSUM_EN): push 8'h01..8'h08, cs_n = 0, model serialiser cnt_bit 0..7 → byte stream A5 5A 08 01 02 03 04 05 06 07 08 24; then valid = 0.
- Insufficient data: push 7 bytes → state stays IDLE and valid = 0; push an 8th → valid = 1 and data_out = A5 next cycle.
- Overflow: push 17 bytes with cs_n = 1 → fifo_full = 1 after the 16th, overflow = 1 after the 17th; the frame later carries bytes 1..8.
- CS pause: raise cs_n during the 4th payload byte for 20 cycles → data_out holds 8'h04; the stream completes correctly after cs_n returns low.
- Without SPI_TX_CSUM_EN, push 16 bytes → two back-to-back 11-byte frames, with exactly one valid = 0 cycle between them.
